// File: rtl/ram_result_storer.sv
// ram_result_storer
//   Write-back end of the brightness pipeline. Accepts packed DEPTH-lane
//   result blocks, clamps each lane to RAM_DATA_WIDTH bits and writes the
//   lanes one byte per clock into the output RAM. Writing starts at address 0
//   and runs up to the top of the RAM. A one-cycle done pulse follows the
//   final write.
//
// Ports
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        begin a frame (honoured only in IDLE)
//   data_in      packed block, lane i = data_in[i*PE_DATA_WIDTH +: PE_DATA_WIDTH]
//   data_valid   data_in holds a block this cycle
//   ready        block accepted at this edge if data_valid=1
//   ram_address  registered RAM write address
//   ram_data     registered clamped write data
//   ram_wren     registered RAM write enable
//   sat_count    number of lanes clamped in the current frame (saturating)
//   overrun      sticky: a block was offered while busy (cleared by start)
//   done         one-cycle pulse after the last write of a frame
module ram_result_storer #(
  parameter int RAM_ADDR_WIDTH = 6,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int PE_DATA_WIDTH  = 16,
  parameter int DEPTH          = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [PE_DATA_WIDTH*DEPTH-1:0]    data_in,
  input  logic                              data_valid,
  output logic                              ready,
  output logic [RAM_ADDR_WIDTH-1:0]         ram_address,
  output logic [RAM_DATA_WIDTH-1:0]         ram_data,
  output logic                              ram_wren,
  output logic [RAM_ADDR_WIDTH:0]           sat_count,
  output logic                              overrun,
  output logic                              done
);

  localparam int LANE_W = $clog2(DEPTH) + 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_BASE =
    RAM_ADDR_WIDTH'((1 << RAM_ADDR_WIDTH) - DEPTH);
  localparam logic [RAM_ADDR_WIDTH-1:0] BLOCK_STEP = RAM_ADDR_WIDTH'(DEPTH);
  localparam logic [PE_DATA_WIDTH-1:0]  CLAMP_MAX  =
    PE_DATA_WIDTH'((1 << RAM_DATA_WIDTH) - 1);
  localparam logic [LANE_W-1:0]         LAST_LANE  = LANE_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    WRITE     = 2'd2,
    DONE_ST   = 2'd3
  } state_t;

  state_t                        state;
  logic [RAM_ADDR_WIDTH-1:0]     base_addr;
  logic [LANE_W-1:0]             lane;
  logic [IDX_W-1:0]              lane_idx;
  logic [PE_DATA_WIDTH-1:0]      block_p0 [DEPTH];
  logic [PE_DATA_WIDTH-1:0]      lane0_in;
  logic [PE_DATA_WIDTH-1:0]      lane_p0;

  function automatic logic is_clamped(input logic [PE_DATA_WIDTH-1:0] x);
    return (x > CLAMP_MAX);
  endfunction

  function automatic logic [RAM_DATA_WIDTH-1:0] clamp(input logic [PE_DATA_WIDTH-1:0] x);
    logic [RAM_DATA_WIDTH-1:0] r;
    if (x > CLAMP_MAX) r = '1;
    else               r = x[RAM_DATA_WIDTH-1:0];
    return r;
  endfunction

  // Counts up by one on a clamped lane, holding at all-ones.
  function automatic logic [RAM_ADDR_WIDTH:0] sat_inc(input logic [RAM_ADDR_WIDTH:0] c,
                                                      input logic hit);
    logic [RAM_ADDR_WIDTH:0] r;
    if (hit && (c != '1)) r = c + 1'b1;
    else                  r = c;
    return r;
  endfunction

  assign ready    = (state == WAIT_DATA);
  assign lane_idx = lane[IDX_W-1:0];
  assign lane0_in = data_in[PE_DATA_WIDTH-1:0];
  assign lane_p0  = block_p0[lane_idx];

  // Stage p0: capture the whole block when it is accepted; lane 0 goes out
  // directly from data_in on the same edge, the rest are read back from here.
  always_ff @(posedge clk) begin
    if (ready && data_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        block_p0[i] <= data_in[i*PE_DATA_WIDTH +: PE_DATA_WIDTH];
      end
    end
  end

  // Stage p1: control FSM and registered RAM write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      base_addr   <= '0;
      lane        <= '0;
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      sat_count   <= '0;
      overrun     <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= WAIT_DATA;
            base_addr <= '0;
            sat_count <= '0;
            overrun   <= 1'b0;
          end
        end

        WAIT_DATA: begin
          if (data_valid) begin
            ram_wren    <= 1'b1;
            ram_address <= base_addr;
            ram_data    <= clamp(lane0_in);
            sat_count   <= sat_inc(sat_count, is_clamped(lane0_in));
            lane        <= LANE_W'(1);
            state       <= WRITE;
          end
        end

        WRITE: begin
          // Any block offered here is dropped.
          if (data_valid) overrun <= 1'b1;
          if (lane == LAST_LANE) begin
            ram_wren  <= 1'b0;
            base_addr <= base_addr + BLOCK_STEP;
            lane      <= '0;
            if (base_addr == LAST_BASE) begin
              state <= DONE_ST;
              done  <= 1'b1;
            end else begin
              state <= WAIT_DATA;
            end
          end else begin
            ram_address <= base_addr + RAM_ADDR_WIDTH'(lane);
            ram_data    <= clamp(lane_p0);
            sat_count   <= sat_inc(sat_count, is_clamped(lane_p0));
            lane        <= lane + 1'b1;
          end
        end

        DONE_ST: begin
          if (data_valid) overrun <= 1'b1;
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
